// File: rtl/esteira_sequenciador.sv
// esteira_sequenciador: conveyor occupancy shift register with tick-paced stepping,
// stall detection on unready stations and a jam fault after a run of blocked ticks.
module esteira_sequenciador #(
    parameter int N_ESTACOES    = 4,
    parameter int TICK_DIV      = 50000000,
    parameter int TIMEOUT_TICKS = 5,
    parameter int CONT_W        = 8
) (
    input  logic                  CLOCK,
    input  logic                  RESET_N,
    input  logic                  START,
    input  logic                  MOTOR_ATIVO,
    input  logic                  MODO_PIPELINE,
    input  logic                  ENTRADA_DISPONIVEL,
    input  logic [N_ESTACOES-1:0] ESTACAO_PRONTA,
    input  logic                  LIMPAR_FALHA,
    output logic [N_ESTACOES-1:0] GARRAFA_PRESENTE,
    output logic                  AVANCO,
    output logic                  GARRAFA_SAIDA,
    output logic [CONT_W-1:0]     CONT_SAIDA,
    output logic                  FALHA_TRAVAMENTO,
    output logic [1:0]            ESTADO
);
    typedef enum logic [1:0] {IDLE, RUN, STALL, FAULT} estado_t;
    localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam int SW = $clog2(TIMEOUT_TICKS + 1);
    estado_t estado;
    logic [TW-1:0] cnt_tick;
    logic [SW-1:0] cnt_stall, stall_next;
    logic run_ok, tick, blocked, insert;
    assign run_ok     = START & MOTOR_ATIVO;
    assign tick       = cnt_tick == TW'(TICK_DIV - 1);
    assign blocked    = |(GARRAFA_PRESENTE & ~ESTACAO_PRONTA);
    // single-bottle mode only admits a new bottle onto an empty belt
    assign insert     = ENTRADA_DISPONIVEL & (MODO_PIPELINE | ~|GARRAFA_PRESENTE);
    assign stall_next = cnt_stall + 1'b1;
    assign ESTADO     = estado;
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            estado           <= IDLE;
            cnt_tick         <= '0;
            cnt_stall        <= '0;
            GARRAFA_PRESENTE <= '0;
            AVANCO           <= 1'b0;
            GARRAFA_SAIDA    <= 1'b0;
            CONT_SAIDA       <= '0;
            FALHA_TRAVAMENTO <= 1'b0;
        end else begin
            AVANCO        <= 1'b0;
            GARRAFA_SAIDA <= 1'b0;
            case (estado)
                IDLE: begin
                    cnt_tick <= '0;
                    if (run_ok) estado <= RUN;
                end
                RUN, STALL: begin
                    cnt_tick <= tick ? '0 : cnt_tick + 1'b1;
                    if (!run_ok) begin
                        estado    <= IDLE;
                        cnt_tick  <= '0;
                        cnt_stall <= '0;
                    end else if (tick && blocked) begin
                        cnt_stall <= stall_next;
                        if (stall_next == SW'(TIMEOUT_TICKS)) begin
                            estado           <= FAULT;
                            FALHA_TRAVAMENTO <= 1'b1;
                        end else begin
                            estado <= STALL;
                        end
                    end else if (tick) begin
                        estado           <= RUN;
                        cnt_stall        <= '0;
                        GARRAFA_PRESENTE <= {GARRAFA_PRESENTE[N_ESTACOES-2:0], insert};
                        AVANCO           <= 1'b1;
                        if (GARRAFA_PRESENTE[N_ESTACOES-1]) begin
                            GARRAFA_SAIDA <= 1'b1;
                            CONT_SAIDA    <= CONT_SAIDA + 1'b1;
                        end
                    end
                end
                FAULT: begin
                    cnt_tick <= '0;
                    if (LIMPAR_FALHA) begin
                        estado           <= IDLE;
                        FALHA_TRAVAMENTO <= 1'b0;
                        cnt_stall        <= '0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_esteira_sequenciador.sv
// tb_esteira_sequenciador: directed scenarios plus randomized run against a slot-level belt model.
module tb_esteira_sequenciador;
    localparam int N = 4, TD = 4, TO = 3, CW = 8;
    logic CLOCK = 1'b0, RESET_N = 1'b0, START = 1'b0, MOTOR_ATIVO = 1'b0, MODO_PIPELINE = 1'b0;
    logic ENTRADA_DISPONIVEL = 1'b0, LIMPAR_FALHA = 1'b0;
    logic [N-1:0] ESTACAO_PRONTA = '1, GARRAFA_PRESENTE;
    logic AVANCO, GARRAFA_SAIDA, FALHA_TRAVAMENTO;
    logic [CW-1:0] CONT_SAIDA;
    logic [1:0] ESTADO;
    int checks = 0, errors = 0;

    esteira_sequenciador #(.N_ESTACOES(N), .TICK_DIV(TD), .TIMEOUT_TICKS(TO), .CONT_W(CW)) dut (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .START(START), .MOTOR_ATIVO(MOTOR_ATIVO),
        .MODO_PIPELINE(MODO_PIPELINE), .ENTRADA_DISPONIVEL(ENTRADA_DISPONIVEL),
        .ESTACAO_PRONTA(ESTACAO_PRONTA), .LIMPAR_FALHA(LIMPAR_FALHA),
        .GARRAFA_PRESENTE(GARRAFA_PRESENTE), .AVANCO(AVANCO), .GARRAFA_SAIDA(GARRAFA_SAIDA),
        .CONT_SAIDA(CONT_SAIDA), .FALHA_TRAVAMENTO(FALHA_TRAVAMENTO), .ESTADO(ESTADO));

    always #5 CLOCK = ~CLOCK;

    // Reference: each slot holds a bottle id (0 = empty); time measured in cycles since the last step.
    int m_state, m_phase, m_stalls, m_exits, next_id;
    int slots [N];
    bit m_av, m_sa, m_flt, ok, blk, tk, empty;
    always @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            m_state = 0; m_phase = 0; m_stalls = 0; m_exits = 0;
            m_av = 0; m_sa = 0; m_flt = 0;
            foreach (slots[i]) slots[i] = 0;
        end else begin
            ok = START && MOTOR_ATIVO;
            blk = 0; empty = 1;
            foreach (slots[i]) begin
                if (slots[i] != 0) empty = 0;
                if (slots[i] != 0 && !ESTACAO_PRONTA[i]) blk = 1;
            end
            tk = (m_state == 1 || m_state == 2) && m_phase == TD - 1;
            m_av = 0; m_sa = 0;
            if (m_state == 0) begin
                m_phase = 0;
                if (ok) m_state = 1;
            end else if (m_state == 3) begin
                if (LIMPAR_FALHA) begin m_state = 0; m_flt = 0; m_stalls = 0; end
            end else if (!ok) begin
                m_state = 0; m_phase = 0; m_stalls = 0;
            end else if (!tk) begin
                m_phase = m_phase + 1;
            end else begin
                m_phase = 0;
                if (blk) begin
                    m_stalls = m_stalls + 1;
                    if (m_stalls >= TO) begin m_state = 3; m_flt = 1; m_phase = 0; end
                    else m_state = 2;
                end else begin
                    m_av = 1; m_stalls = 0; m_state = 1;
                    if (slots[N-1] != 0) begin m_sa = 1; m_exits = (m_exits + 1) % (1 << CW); end
                    for (int i = N - 1; i > 0; i--) slots[i] = slots[i-1];
                    if (ENTRADA_DISPONIVEL && (MODO_PIPELINE || empty)) begin
                        next_id = next_id + 1; slots[0] = next_id;
                    end else slots[0] = 0;
                end
            end
        end
    end

    task automatic clk_n(input int n);
        repeat (n) @(posedge CLOCK);
        #1;
    endtask

    task automatic do_reset();
        RESET_N = 1'b0; START = 1'b0; MOTOR_ATIVO = 1'b0; LIMPAR_FALHA = 1'b0;
        ENTRADA_DISPONIVEL = 1'b0; MODO_PIPELINE = 1'b0; ESTACAO_PRONTA = '1;
        clk_n(1);
        RESET_N = 1'b1;
    endtask

    task automatic go(input logic pipe);
        MODO_PIPELINE = pipe; ENTRADA_DISPONIVEL = 1'b1; ESTACAO_PRONTA = '1;
        START = 1'b1; MOTOR_ATIVO = 1'b1;
        clk_n(1);
    endtask

    task automatic test_reset();
        START = 1'b1; MOTOR_ATIVO = 1'b1;
        clk_n(2);
        checks++;
        if (ESTADO !== 2'd0 || GARRAFA_PRESENTE !== 4'd0 || AVANCO !== 1'b0 || GARRAFA_SAIDA !== 1'b0 ||
            CONT_SAIDA !== 8'd0 || FALHA_TRAVAMENTO !== 1'b0) begin
            errors++;
            $display("FAIL reset got est=%0d occ=%b av=%b sa=%b cnt=%0d flt=%b want all zero",
                     ESTADO, GARRAFA_PRESENTE, AVANCO, GARRAFA_SAIDA, CONT_SAIDA, FALHA_TRAVAMENTO);
        end
    endtask

    task automatic test_pipeline();
        logic [3:0] exp_occ;
        do_reset();
        go(1'b1);
        checks++;
        if (ESTADO !== 2'd1) begin errors++; $display("FAIL pipe_run got %0d want 1", ESTADO); end
        for (int k = 1; k <= 8; k++) begin
            clk_n(TD);
            exp_occ = k < 4 ? 4'((1 << k) - 1) : 4'b1111;
            checks++;
            if (GARRAFA_PRESENTE !== exp_occ || AVANCO !== 1'b1 || GARRAFA_SAIDA !== (k >= 5) ||
                CONT_SAIDA !== 8'(k >= 5 ? k - 4 : 0)) begin
                errors++;
                $display("FAIL pipe_step%0d got occ=%b av=%b sa=%b cnt=%0d want occ=%b av=1 sa=%b cnt=%0d",
                         k, GARRAFA_PRESENTE, AVANCO, GARRAFA_SAIDA, CONT_SAIDA, exp_occ, k >= 5, k >= 5 ? k - 4 : 0);
            end
        end
        clk_n(1);
        checks++;
        if (AVANCO !== 1'b0 || GARRAFA_SAIDA !== 1'b0) begin
            errors++; $display("FAIL pipe_pulse_width got av=%b sa=%b want 0 0", AVANCO, GARRAFA_SAIDA);
        end
    endtask

    task automatic test_single();
        logic [3:0] seq [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0001};
        do_reset();
        go(1'b0);
        for (int k = 0; k < 6; k++) begin
            clk_n(TD);
            checks++;
            if (GARRAFA_PRESENTE !== seq[k] || GARRAFA_SAIDA !== (k == 4) || $countones(GARRAFA_PRESENTE) > 1) begin
                errors++;
                $display("FAIL single_step%0d got occ=%b sa=%b want occ=%b sa=%b",
                         k + 1, GARRAFA_PRESENTE, GARRAFA_SAIDA, seq[k], k == 4);
            end
        end
    endtask

    task automatic to_station1();
        do_reset();
        go(1'b0);
        clk_n(2 * TD);
        ENTRADA_DISPONIVEL = 1'b0;
        ESTACAO_PRONTA = 4'b1101;
    endtask

    task automatic test_stall();
        to_station1();
        for (int k = 1; k <= 2; k++) begin
            clk_n(TD);
            checks++;
            if (ESTADO !== 2'd2 || AVANCO !== 1'b0 || GARRAFA_PRESENTE !== 4'b0010) begin
                errors++;
                $display("FAIL stall_tick%0d got est=%0d av=%b occ=%b want 2 0 0010", k, ESTADO, AVANCO, GARRAFA_PRESENTE);
            end
        end
        ESTACAO_PRONTA = 4'b1111;
        clk_n(TD);
        checks++;
        if (ESTADO !== 2'd1 || AVANCO !== 1'b1 || GARRAFA_PRESENTE !== 4'b0100) begin
            errors++;
            $display("FAIL stall_recover got est=%0d av=%b occ=%b want 1 1 0100", ESTADO, AVANCO, GARRAFA_PRESENTE);
        end
    endtask

    task automatic test_fault();
        bit bad = 0;
        to_station1();
        clk_n(3 * TD);
        checks++;
        if (ESTADO !== 2'd3 || FALHA_TRAVAMENTO !== 1'b1) begin
            errors++; $display("FAIL fault_enter got est=%0d flt=%b want 3 1", ESTADO, FALHA_TRAVAMENTO);
        end
        ESTACAO_PRONTA = 4'b1111;
        for (int k = 0; k < 12; k++) begin
            START = ~START;
            clk_n(1);
            if (ESTADO !== 2'd3 || AVANCO !== 1'b0) bad = 1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL fault_hold got left FAULT or stepped want stay 3"); end
        START = 1'b1; LIMPAR_FALHA = 1'b1;
        clk_n(1);
        LIMPAR_FALHA = 1'b0;
        checks++;
        if (ESTADO !== 2'd0 || FALHA_TRAVAMENTO !== 1'b0 || GARRAFA_PRESENTE !== 4'b0010) begin
            errors++;
            $display("FAIL fault_clear got est=%0d flt=%b occ=%b want 0 0 0010", ESTADO, FALHA_TRAVAMENTO, GARRAFA_PRESENTE);
        end
        clk_n(1);
        LIMPAR_FALHA = 1'b1;
        clk_n(1);
        LIMPAR_FALHA = 1'b0;
        checks++;
        if (ESTADO !== 2'd1 || FALHA_TRAVAMENTO !== 1'b0) begin
            errors++; $display("FAIL clear_outside_fault got est=%0d flt=%b want 1 0", ESTADO, FALHA_TRAVAMENTO);
        end
    endtask

    task automatic test_stop();
        do_reset();
        go(1'b1);
        clk_n(TD - 1);
        START = 1'b0;
        clk_n(1);
        checks++;
        if (ESTADO !== 2'd0 || AVANCO !== 1'b0 || GARRAFA_PRESENTE !== 4'b0000) begin
            errors++;
            $display("FAIL stop_on_tick got est=%0d av=%b occ=%b want 0 0 0000", ESTADO, AVANCO, GARRAFA_PRESENTE);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        go(1'b1);
        clk_n(2 * TD);
        #2 RESET_N = 1'b0;
        #1;
        checks++;
        if (ESTADO !== 2'd0 || GARRAFA_PRESENTE !== 4'd0 || AVANCO !== 1'b0 || GARRAFA_SAIDA !== 1'b0 ||
            CONT_SAIDA !== 8'd0 || FALHA_TRAVAMENTO !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got est=%0d occ=%b av=%b sa=%b cnt=%0d flt=%b want all zero",
                     ESTADO, GARRAFA_PRESENTE, AVANCO, GARRAFA_SAIDA, CONT_SAIDA, FALHA_TRAVAMENTO);
        end
        clk_n(1);
        RESET_N = 1'b1;
    endtask

    task automatic test_wrap();
        do_reset();
        go(1'b1);
        for (int k = 1; k <= 260; k++) begin
            clk_n(TD);
            if (k == 259) begin
                checks++;
                if (CONT_SAIDA !== 8'd255) begin errors++; $display("FAIL wrap_255 got %0d want 255", CONT_SAIDA); end
            end
            if (k == 260) begin
                checks++;
                if (CONT_SAIDA !== 8'd0 || GARRAFA_SAIDA !== 1'b1) begin
                    errors++; $display("FAIL wrap_0 got cnt=%0d sa=%b want 0 1", CONT_SAIDA, GARRAFA_SAIDA);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [N-1:0] exp_occ;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            START = $urandom_range(0, 99) < 97;
            MOTOR_ATIVO = $urandom_range(0, 99) < 98;
            if ($urandom_range(0, 49) == 0) MODO_PIPELINE = ~MODO_PIPELINE;
            ENTRADA_DISPONIVEL = $urandom_range(0, 99) < 70;
            for (int i = 0; i < N; i++) ESTACAO_PRONTA[i] = $urandom_range(0, 99) < 88;
            LIMPAR_FALHA = $urandom_range(0, 19) == 0;
            clk_n(1);
            for (int i = 0; i < N; i++) exp_occ[i] = slots[i] != 0;
            checks++;
            if (ESTADO !== 2'(m_state) || GARRAFA_PRESENTE !== exp_occ || AVANCO !== m_av || GARRAFA_SAIDA !== m_sa ||
                CONT_SAIDA !== 8'(m_exits) || FALHA_TRAVAMENTO !== m_flt) begin
                errors++;
                $display("FAIL random_c%0d got est=%0d occ=%b av=%b sa=%b cnt=%0d flt=%b want %0d %b %b %b %0d %b",
                         c, ESTADO, GARRAFA_PRESENTE, AVANCO, GARRAFA_SAIDA, CONT_SAIDA, FALHA_TRAVAMENTO,
                         m_state, exp_occ, m_av, m_sa, m_exits, m_flt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_pipeline();
        test_single();
        test_stall();
        test_fault();
        test_stop();
        test_async_reset();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
